// File: rtl/stream_mux_rr.sv
// stream_mux_rr: registered N-to-1 stream mux, manual or round-robin select.
// Ports: clk, rst_n; mode, sel; in_data/in_valid/in_ready per channel;
// out_data/out_chan/out_valid registered, out_ready from the consumer.
module stream_mux_rr #(
  parameter  int WIDTH = 8,
  parameter  int N     = 4,
  localparam int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_chan,
  output logic               out_valid,
  input  logic               out_ready
);

  logic             load_en;
  logic             gnt_vld;
  logic [SELW-1:0]  gnt;
  logic [SELW-1:0]  last_grant;
  logic [WIDTH-1:0] gnt_data;

  assign load_en = !out_valid || out_ready;

  always_comb begin : grant_sel
    int idx;
    gnt_vld = 1'b0;
    gnt     = '0;
    idx     = 0;
    if (!mode) begin
      // sel >= N never matches any channel
      for (int i = 0; i < N; i++) begin
        if (sel == SELW'(i) && in_valid[i]) begin
          gnt_vld = 1'b1;
          gnt     = SELW'(i);
        end
      end
    end else begin
      // Farthest offset first, so the nearest
      // valid channel after last_grant wins.
      for (int k = N; k >= 1; k--) begin
        idx = int'(last_grant) + k;
        if (idx >= N) idx -= N;
        if (in_valid[idx]) begin
          gnt_vld = 1'b1;
          gnt     = SELW'(idx);
        end
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt == SELW'(i))
        gnt_data = in_data[i*WIDTH +: WIDTH];
      in_ready[i] = load_en && gnt_vld &&
                    (gnt == SELW'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_chan   <= '0;
      last_grant <= SELW'(N - 1);
    end else if (load_en) begin
      out_valid <= gnt_vld;
      if (gnt_vld) begin
        out_data   <= gnt_data;
        out_chan   <= gnt;
        last_grant <= gnt;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: directed bench for stream_mux_rr at N=4 and N=3.
// Expected output words are queued on input transfer, popped on output.
module tb_stream_mux_rr;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode;
  logic [1:0]  sel;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic        out_ready;
  logic        use3;

  logic [3:0] rdy4;
  logic [2:0] rdy3;
  logic [7:0] od4, od3;
  logic [1:0] ch4, ch3;
  logic       ov4, ov3;

  logic [3:0] rdy;
  logic [7:0] od;
  logic [1:0] ch;
  logic       ov;

  int errors = 0;
  int checks = 0;
  bit m_ov;
  logic [9:0] q[$];

  always #5 clk = ~clk;

  stream_mux_rr #(.WIDTH(8), .N(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy4), .out_data(od4), .out_chan(ch4),
    .out_valid(ov4), .out_ready(out_ready)
  );

  stream_mux_rr #(.WIDTH(8), .N(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_data(in_data[23:0]), .in_valid(in_valid[2:0]),
    .in_ready(rdy3), .out_data(od3), .out_chan(ch3),
    .out_valid(ov3), .out_ready(out_ready)
  );

  assign rdy = use3 ? {1'b0, rdy3} : rdy4;
  assign od  = use3 ? od3 : od4;
  assign ch  = use3 ? ch3 : ch4;
  assign ov  = use3 ? ov3 : ov4;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One clock: check the pre-edge state, then advance.
  task automatic step(input logic [3:0] exp_rdy);
    bit ld;
    logic [9:0] e;
    #2;
    ld = !m_ov || out_ready;
    chk("in_ready", rdy, exp_rdy);
    chk("out_valid", ov, m_ov);
    if (m_ov && out_ready) begin
      if (q.size() == 0) begin
        chk("sb_nonempty", q.size(), 1);
      end else begin
        e = q.pop_front();
        chk("out_chan", ch, e[9:8]);
        chk("out_data", od, e[7:0]);
      end
    end
    if (ld) m_ov = (exp_rdy != 0);
    if (ld) begin
      for (int i = 0; i < 4; i++)
        if (exp_rdy[i])
          q.push_back({2'(i), in_data[i*8 +: 8]});
    end
    @(posedge clk);
    #1;
  endtask

  // Mid-cycle async reset; outputs must clear at once.
  task automatic do_reset();
    #3;
    in_valid = '0;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", ov, 0);
    chk("rst_data", od, 0);
    chk("rst_chan", ch, 0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    q.delete();
    m_ov = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    mode = 1'b0;
    sel = '0;
    in_data = 32'hA3A2A1A0;
    in_valid = '0;
    out_ready = 1'b0;
    use3 = 1'b0;
    m_ov = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // reset with a held word
    mode = 1'b1;
    in_valid = 4'b1111;
    step(4'b0001);
    step(4'b0000);
    do_reset();
    in_valid = 4'b1111;
    out_ready = 1'b1;
    step(4'b0001);

    // manual select
    mode = 1'b0;
    sel = 2'd2;
    step(4'b0100);
    step(4'b0100);
    step(4'b0100);
    in_valid = 4'b1011;
    step(4'b0000);
    step(4'b0000);

    // round-robin with a gap
    do_reset();
    mode = 1'b1;
    in_valid = 4'b1011;
    step(4'b0001);
    step(4'b0010);
    step(4'b1000);
    step(4'b0001);
    step(4'b0010);
    step(4'b1000);

    // stall
    in_data = 32'hA3A26655;
    step(4'b0001);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(4'b0000);
      chk("stall_data", od, 8'h55);
    end
    out_ready = 1'b1;
    step(4'b0010);
    step(4'b1000);

    // manual transfer moves the rr pointer
    mode = 1'b0;
    sel = 2'd1;
    in_valid = 4'b1111;
    step(4'b0010);
    mode = 1'b1;
    step(4'b0100);
    step(4'b1000);
    in_valid = 4'b0000;
    step(4'b0000);
    step(4'b0000);

    // N=3: out-of-range select, then rotation
    use3 = 1'b1;
    in_data = 32'h00B2B1B0;
    do_reset();
    mode = 1'b0;
    sel = 2'd3;
    in_valid = 4'b0111;
    step(4'b0000);
    step(4'b0000);
    mode = 1'b1;
    step(4'b0001);
    step(4'b0010);
    step(4'b0100);
    step(4'b0001);
    in_valid = 4'b0000;
    step(4'b0000);
    step(4'b0000);
    chk("sb_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
